// File: rtl/fmc_port_arb_if.sv
// fmc_port_arb_if: membus/fast-memory side bundle for the fast-memory port arbiter.
//   membus_rq_cyc/fmc_select/sel/rd_rq/wr_rq/wr_rs : per-port request and strobe lines (4 ports)
//   fm_addr_ack/fm_rd_rs                           : handshake pulses from the fast memory
//   grant/grant_id/busy/tmo_err                    : arbiter results
// master: the request/strobe driver side. slave: the arbiter.
interface fmc_port_arb_if;
  logic [3:0]  membus_rq_cyc;
  logic [3:0]  membus_fmc_select;
  logic [15:0] membus_sel;
  logic [3:0]  membus_rd_rq;
  logic [3:0]  membus_wr_rq;
  logic [3:0]  membus_wr_rs;
  logic        fm_addr_ack;
  logic        fm_rd_rs;
  logic [3:0]  grant;
  logic [1:0]  grant_id;
  logic        busy;
  logic        tmo_err;

  modport master (
    output membus_rq_cyc, membus_fmc_select, membus_sel, membus_rd_rq, membus_wr_rq,
           membus_wr_rs, fm_addr_ack, fm_rd_rs,
    input  grant, grant_id, busy, tmo_err
  );

  modport slave (
    input  membus_rq_cyc, membus_fmc_select, membus_sel, membus_rd_rq, membus_wr_rq,
           membus_wr_rs, fm_addr_ack, fm_rd_rs,
    output grant, grant_id, busy, tmo_err
  );
endinterface

// File: rtl/fmc_port_arb.sv
// fmc_port_arb: dynamic round-robin arbiter granting one of four membus ports to the fast memory.
// The grant is held through the read, write or read-modify-write handshake, then dropped for
// GAP_CYCLES cycles before arbitration resumes.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-high; drops any grant immediately
//   bus   : fmc_port_arb_if.slave (membus requests/strobes, fm handshakes, grant outputs)
module fmc_port_arb #(
  parameter logic [3:0]  MEMSEL_P0  = 4'b0,
  parameter logic [3:0]  MEMSEL_P1  = 4'b0,
  parameter logic [3:0]  MEMSEL_P2  = 4'b0,
  parameter logic [3:0]  MEMSEL_P3  = 4'b0,
  parameter logic [3:0]  PORT_EN    = 4'b1111,
  parameter int unsigned TMO_CYCLES = 1024,
  parameter int unsigned GAP_CYCLES = 2
) (
  input logic           clk,
  input logic           reset,
  fmc_port_arb_if.slave bus
);

  localparam logic [15:0] MemSel = {MEMSEL_P3, MEMSEL_P2, MEMSEL_P1, MEMSEL_P0};
  localparam int unsigned CntMax = (TMO_CYCLES > GAP_CYCLES) ? TMO_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax) + 1;
  localparam logic [CntW-1:0] TmoLast = CntW'(TMO_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast = CntW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StAddr, StRd, StWr, StRel} state_e;

  state_e          state_q;
  logic [3:0]      grant_q;
  logic [1:0]      grant_id_q;
  logic            tmo_err_q;
  logic [CntW-1:0] cnt_q;

  logic [3:0] eligible;
  logic       pick_valid;
  logic [1:0] pick_id;
  logic [1:0] idx;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      eligible[i] = PORT_EN[i] & bus.membus_rq_cyc[i] & bus.membus_fmc_select[i] &
                    (bus.membus_sel[4*i +: 4] == MemSel[4*i +: 4]);
    end
  end

  // Round-robin: search upward from the port after the last grant; the last-granted port is
  // checked last (offset 4 wraps to itself).
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = grant_id_q;
    idx        = grant_id_q;
    for (int i = 1; i <= 4; i++) begin
      idx = grant_id_q + 2'(i);
      if (!pick_valid && eligible[idx]) begin
        pick_valid = 1'b1;
        pick_id    = idx;
      end
    end
  end

  // cnt_q is cleared on every state entry; it times the wait states and the release gap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      grant_q    <= 4'b0000;
      grant_id_q <= 2'd3;
      tmo_err_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      tmo_err_q <= 1'b0;
      cnt_q     <= cnt_q + 1'b1;
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (pick_valid) begin
            state_q    <= StAddr;
            grant_q    <= 4'b0001 << pick_id;
            grant_id_q <= pick_id;
          end
        end
        StAddr: begin
          // Ack beats both the abort and the timeout; a coincident rd_rs is dropped.
          if (bus.fm_addr_ack) begin
            cnt_q <= '0;
            if (bus.membus_rd_rq[grant_id_q]) begin
              state_q <= StRd;
            end else if (bus.membus_wr_rq[grant_id_q]) begin
              state_q <= StWr;
            end else begin
              state_q <= StRel;
              grant_q <= 4'b0000;
            end
          end else if (!eligible[grant_id_q]) begin
            state_q <= StRel;
            grant_q <= 4'b0000;
            cnt_q   <= '0;
          end else if (cnt_q == TmoLast) begin
            state_q   <= StRel;
            grant_q   <= 4'b0000;
            tmo_err_q <= 1'b1;
            cnt_q     <= '0;
          end
        end
        StRd: begin
          if (bus.fm_rd_rs) begin
            cnt_q <= '0;
            if (bus.membus_wr_rq[grant_id_q]) begin
              state_q <= StWr;
            end else begin
              state_q <= StRel;
              grant_q <= 4'b0000;
            end
          end else if (cnt_q == TmoLast) begin
            state_q   <= StRel;
            grant_q   <= 4'b0000;
            tmo_err_q <= 1'b1;
            cnt_q     <= '0;
          end
        end
        StWr: begin
          if (bus.membus_wr_rs[grant_id_q]) begin
            state_q <= StRel;
            grant_q <= 4'b0000;
            cnt_q   <= '0;
          end else if (cnt_q == TmoLast) begin
            state_q   <= StRel;
            grant_q   <= 4'b0000;
            tmo_err_q <= 1'b1;
            cnt_q     <= '0;
          end
        end
        StRel: begin
          if (cnt_q == GapLast) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= StIdle;
          grant_q <= 4'b0000;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.grant    = grant_q;
  assign bus.grant_id = grant_id_q;
  assign bus.busy     = (state_q != StIdle);
  assign bus.tmo_err  = tmo_err_q;

endmodule

// File: tb/tb_fmc_port_arb.sv
// tb_fmc_port_arb: vector-table and scoreboard bench for fmc_port_arb.
// Each vector drives one cycle of inputs and pushes the outputs expected after the next clock
// edge; the entry is popped and compared one time unit after that edge.
module tb_fmc_port_arb;

  localparam logic [15:0] SelOk = 16'h4321;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fmc_port_arb_if bus ();
  fmc_port_arb_if bus2 ();

  // Second instance with port 0 disabled sees the same stimulus.
  assign bus2.membus_rq_cyc     = bus.membus_rq_cyc;
  assign bus2.membus_fmc_select = bus.membus_fmc_select;
  assign bus2.membus_sel        = bus.membus_sel;
  assign bus2.membus_rd_rq      = bus.membus_rd_rq;
  assign bus2.membus_wr_rq      = bus.membus_wr_rq;
  assign bus2.membus_wr_rs      = bus.membus_wr_rs;
  assign bus2.fm_addr_ack       = bus.fm_addr_ack;
  assign bus2.fm_rd_rs          = bus.fm_rd_rs;

  fmc_port_arb #(
    .MEMSEL_P0(4'h1), .MEMSEL_P1(4'h2), .MEMSEL_P2(4'h3), .MEMSEL_P3(4'h4),
    .PORT_EN(4'b1111), .TMO_CYCLES(16), .GAP_CYCLES(2)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  fmc_port_arb #(
    .MEMSEL_P0(4'h1), .MEMSEL_P1(4'h2), .MEMSEL_P2(4'h3), .MEMSEL_P3(4'h4),
    .PORT_EN(4'b1110), .TMO_CYCLES(16), .GAP_CYCLES(2)
  ) dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  typedef struct packed {
    logic [3:0]  rq;
    logic [3:0]  fsel;
    logic [15:0] sel;
    logic [3:0]  rd;
    logic [3:0]  wr;
    logic [3:0]  wrs;
    logic        ack;
    logic        rds;
    logic [3:0]  g;
    logic [1:0]  id;
    logic        b;
    logic        t;
  } vec_t;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] id;
    logic       busy;
    logic       tmo;
  } exp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  vec_t tbl[$];

  function automatic vec_t v(input logic [3:0] rq, rd, wr, wrs, input logic ack, rds,
                             input logic [3:0] g, input logic [1:0] id, input logic b, t);
    vec_t x;
    x.rq = rq; x.fsel = rq; x.sel = SelOk; x.rd = rd; x.wr = wr; x.wrs = wrs;
    x.ack = ack; x.rds = rds; x.g = g; x.id = id; x.b = b; x.t = t;
    return x;
  endfunction

  function automatic logic [7:0] dut_out();
    return {bus.grant, bus.grant_id, bus.busy, bus.tmo_err};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got grant=%b id=%0d busy=%b tmo=%b, want grant=%b id=%0d busy=%b tmo=%b",
               name, act[7:4], act[3:2], act[1], act[0], exp[7:4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  task automatic drive_idle();
    bus.membus_rq_cyc = '0; bus.membus_fmc_select = '0; bus.membus_sel = SelOk;
    bus.membus_rd_rq = '0; bus.membus_wr_rq = '0; bus.membus_wr_rs = '0;
    bus.fm_addr_ack = 1'b0; bus.fm_rd_rs = 1'b0;
  endtask

  task automatic apply(input vec_t x, input string tag);
    exp_t e;
    bus.membus_rq_cyc = x.rq; bus.membus_fmc_select = x.fsel; bus.membus_sel = x.sel;
    bus.membus_rd_rq = x.rd; bus.membus_wr_rq = x.wr; bus.membus_wr_rs = x.wrs;
    bus.fm_addr_ack = x.ack; bus.fm_rd_rs = x.rds;
    e.grant = x.g; e.id = x.id; e.busy = x.b; e.tmo = x.t;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      check(tag, dut_out(), e);
    end
  endtask

  task automatic run_table(input string label);
    foreach (tbl[i]) apply(tbl[i], $sformatf("%s[%0d]", label, i));
    tbl.delete();
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    drive_idle();
    @(posedge clk);
    #1;
    check(tag, dut_out(), {4'b0000, 2'd3, 1'b0, 1'b0});
    reset = 1'b0;
  endtask

  initial begin
    vec_t x;
    reset = 1'b1;
    drive_idle();
    do_reset("reset_state");

    // Single read on port 2, then release gap.
    tbl.push_back(v(4'b0100, 0, 0, 0, 0, 0, 4'b0100, 2, 1, 0));
    tbl.push_back(v(4'b0100, 4'b0100, 0, 0, 1, 0, 4'b0100, 2, 1, 0));
    tbl.push_back(v(4'b0100, 4'b0100, 0, 0, 0, 0, 4'b0100, 2, 1, 0));
    tbl.push_back(v(4'b0100, 4'b0100, 0, 0, 0, 0, 4'b0100, 2, 1, 0));
    tbl.push_back(v(4'b0100, 4'b0100, 0, 0, 0, 1, 4'b0000, 2, 1, 0));
    tbl.push_back(v(4'b0000, 0, 0, 0, 0, 0, 4'b0000, 2, 1, 0));
    tbl.push_back(v(4'b0000, 0, 0, 0, 0, 0, 4'b0000, 2, 0, 0));
    tbl.push_back(v(4'b0000, 0, 0, 0, 0, 0, 4'b0000, 2, 0, 0));
    run_table("read_p2");

    do_reset("reset_2");
    // Round robin with all four ports requesting: order 0,1,2,3,0.
    for (int k = 0; k < 4; k++) begin
      tbl.push_back(v(4'hF, 0, 0, 0, 0, 0, 4'(1 << k), 2'(k), 1, 0));
      tbl.push_back(v(4'hF, 0, 0, 0, 1, 0, 4'b0000, 2'(k), 1, 0));
      tbl.push_back(v(4'hF, 0, 0, 0, 0, 0, 4'b0000, 2'(k), 1, 0));
      tbl.push_back(v(4'hF, 0, 0, 0, 0, 0, 4'b0000, 2'(k), 0, 0));
    end
    tbl.push_back(v(4'hF, 0, 0, 0, 0, 0, 4'b0001, 0, 1, 0));
    tbl.push_back(v(4'hF, 0, 0, 0, 1, 0, 4'b0000, 0, 1, 0));
    tbl.push_back(v(4'h0, 0, 0, 0, 0, 0, 4'b0000, 0, 1, 0));
    tbl.push_back(v(4'h0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0));
    // Read-modify-write on port 1; port 3 wr_rs must be ignored.
    tbl.push_back(v(4'b0010, 0, 0, 0, 0, 0, 4'b0010, 1, 1, 0));
    tbl.push_back(v(4'b0010, 4'b0010, 4'b0010, 0, 1, 0, 4'b0010, 1, 1, 0));
    tbl.push_back(v(4'b0010, 4'b0010, 4'b0010, 0, 0, 1, 4'b0010, 1, 1, 0));
    tbl.push_back(v(4'b0010, 4'b0010, 4'b0010, 4'b1000, 0, 0, 4'b0010, 1, 1, 0));
    tbl.push_back(v(4'b0010, 4'b0010, 4'b0010, 4'b1000, 0, 0, 4'b0010, 1, 1, 0));
    tbl.push_back(v(4'b0010, 4'b0010, 4'b0010, 0, 0, 0, 4'b0010, 1, 1, 0));
    tbl.push_back(v(4'b0010, 4'b0010, 4'b0010, 0, 0, 0, 4'b0010, 1, 1, 0));
    tbl.push_back(v(4'b0010, 4'b0010, 4'b0010, 4'b0010, 0, 0, 4'b0000, 1, 1, 0));
    tbl.push_back(v(4'b0000, 0, 0, 0, 0, 0, 4'b0000, 1, 1, 0));
    tbl.push_back(v(4'b0000, 0, 0, 0, 0, 0, 4'b0000, 1, 0, 0));
    // Abort: port 0 drops its request before ack, no tmo_err.
    tbl.push_back(v(4'b0001, 0, 0, 0, 0, 0, 4'b0001, 0, 1, 0));
    tbl.push_back(v(4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0, 1, 0));
    tbl.push_back(v(4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0, 1, 0));
    tbl.push_back(v(4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0));
    // Ack and rd_rs together: rd_rs is not remembered, RD waits for a fresh rd_rs.
    tbl.push_back(v(4'b0100, 0, 0, 0, 0, 0, 4'b0100, 2, 1, 0));
    tbl.push_back(v(4'b0100, 4'b0100, 0, 0, 1, 1, 4'b0100, 2, 1, 0));
    tbl.push_back(v(4'b0100, 4'b0100, 0, 0, 0, 0, 4'b0100, 2, 1, 0));
    tbl.push_back(v(4'b0100, 4'b0100, 0, 0, 0, 1, 4'b0000, 2, 1, 0));
    tbl.push_back(v(4'b0000, 0, 0, 0, 0, 0, 4'b0000, 2, 1, 0));
    tbl.push_back(v(4'b0000, 0, 0, 0, 0, 0, 4'b0000, 2, 0, 0));
    run_table("rr_rmw");

    // Timeout: no ack on port 3, tmo_err 16 cycles after the grant appears.
    do_reset("reset_3");
    apply(v(4'b1000, 0, 0, 0, 0, 0, 4'b1000, 3, 1, 0), "tmo_grant");
    for (int k = 1; k < 16; k++) begin
      apply(v(4'b1000, 0, 0, 0, 0, 0, 4'b1000, 3, 1, 0), $sformatf("tmo_wait%0d", k));
    end
    apply(v(4'b1000, 0, 0, 0, 0, 0, 4'b0000, 3, 1, 1), "tmo_fire");
    apply(v(4'b0000, 0, 0, 0, 0, 0, 4'b0000, 3, 1, 0), "tmo_pulse_end");
    apply(v(4'b0000, 0, 0, 0, 0, 0, 4'b0000, 3, 0, 0), "tmo_idle");

    // Ack on the last timeout cycle wins over the timeout.
    apply(v(4'b1000, 0, 0, 0, 0, 0, 4'b1000, 3, 1, 0), "ackt_grant");
    for (int k = 1; k < 16; k++) begin
      apply(v(4'b1000, 0, 0, 0, 0, 0, 4'b1000, 3, 1, 0), $sformatf("ackt_wait%0d", k));
    end
    apply(v(4'b1000, 4'b1000, 0, 0, 1, 0, 4'b1000, 3, 1, 0), "ackt_ack");
    apply(v(4'b1000, 4'b1000, 0, 0, 0, 1, 4'b0000, 3, 1, 0), "ackt_rdrs");
    apply(v(4'b0000, 0, 0, 0, 0, 0, 4'b0000, 3, 1, 0), "ackt_rel");
    apply(v(4'b0000, 0, 0, 0, 0, 0, 4'b0000, 3, 0, 0), "ackt_idle");

    // Asynchronous reset in RD drops the grant without a clock edge.
    do_reset("reset_4");
    apply(v(4'b0010, 0, 0, 0, 0, 0, 4'b0010, 1, 1, 0), "arst_grant");
    apply(v(4'b0010, 4'b0010, 0, 0, 1, 0, 4'b0010, 1, 1, 0), "arst_rd");
    #2;
    reset = 1'b1;
    #1;
    check("arst_immediate", dut_out(), {4'b0000, 2'd3, 1'b0, 1'b0});
    do_reset("arst_release");

    // Port 0 with mismatching sel, then with fmc_select low: never granted.
    for (int k = 0; k < 3; k++) begin
      x = v(4'b0001, 0, 0, 0, 0, 0, 4'b0000, 3, 0, 0);
      x.sel[3:0] = 4'hF;
      apply(x, $sformatf("sel_mismatch%0d", k));
    end
    for (int k = 0; k < 2; k++) begin
      x = v(4'b0001, 0, 0, 0, 0, 0, 4'b0000, 3, 0, 0);
      x.fsel = 4'b0000;
      apply(x, $sformatf("fsel_low%0d", k));
    end

    // Port 0 eligible: granted by the enabled instance, never by the PORT_EN[0]=0 instance.
    apply(v(4'b0001, 0, 0, 0, 0, 0, 4'b0001, 0, 1, 0), "pen_grant");
    check("pen_off_0", {bus2.grant, bus2.grant_id, bus2.busy, 1'b0}, {4'b0000, 2'd3, 1'b0, 1'b0});
    apply(v(4'b0001, 0, 0, 0, 1, 0, 4'b0000, 0, 1, 0), "pen_rel");
    check("pen_off_1", {bus2.grant, bus2.grant_id, bus2.busy, 1'b0}, {4'b0000, 2'd3, 1'b0, 1'b0});
    apply(v(4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0, 1, 0), "pen_gap");
    apply(v(4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0), "pen_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
